// File: rtl/frac_lutk_arith_cfg_tile.sv
// K-input fracturable LUT with carry logic, fed from a double-buffered config chain.
// Optional even-parity check on commit: define FRAC_LUTK_CFG_PARITY_EN.
module frac_lutk_arith_cfg_tile #(
  parameter int LUT_K  = 4,
  parameter int MODE_W = 2
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             config_enable,
  input  logic             ccff_head,
  output logic             ccff_tail,
  input  logic [LUT_K-1:0] frac_in,
  input  logic             cin,
  output logic [1:0]       lut_half_out,
  output logic             lut_out,
  output logic             cout,
  output logic             cfg_done,
  output logic             cfg_err
);
  localparam int SRAM_N = 1 << LUT_K;
`ifdef FRAC_LUTK_CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int CHAIN_LEN = SRAM_N + MODE_W + PAR_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] chain;
  logic [CNT_W-1:0]     cnt;
  // Live config keeps only what the datapath uses: arith flag + table.
  logic                 act_arith;
  logic [SRAM_N-1:0]    act_sram;
  logic                 par_ok;

`ifdef FRAC_LUTK_CFG_PARITY_EN
  assign par_ok = ~^chain;
`else
  assign par_ok = 1'b1;
`endif

  assign ccff_tail = chain[CHAIN_LEN-1];

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      chain     <= '0;
      cnt       <= '0;
      act_arith <= 1'b0;
      act_sram  <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (config_enable) begin
          chain    <= {chain[CHAIN_LEN-2:0], ccff_head};
          cnt      <= CNT_W'(1);
          cfg_done <= 1'b0;
          cfg_err  <= 1'b0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (config_enable) begin
            chain <= {chain[CHAIN_LEN-2:0], ccff_head};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end else if (cnt == CNT_MAX) begin
            state <= COMMIT;
          end else begin
            cfg_err <= 1'b1;
            state   <= IDLE;
          end
        end
        COMMIT: begin
          if (par_ok) begin
            act_sram  <= chain[SRAM_N-1:0];
            act_arith <= chain[SRAM_N+1];
            cfg_done  <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
          // Chain is frozen this cycle; a held enable restarts the count from zero.
          if (config_enable) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [LUT_K-2:0] idx;
  logic             lo, hi;

  assign idx          = frac_in[LUT_K-2:0];
  assign lo           = act_sram[{1'b0, idx}];
  assign hi           = act_sram[{1'b1, idx}];
  assign lut_half_out = {hi, lo};

  // Arithmetic mode: lo is propagate, hi is generate.
  always_comb begin
    lut_out = frac_in[LUT_K-1] ? hi : lo;
    cout    = 1'b0;
    if (act_arith) begin
      lut_out = lo ^ cin;
      cout    = lo ? cin : hi;
    end
  end

endmodule

// File: tb/tb_frac_lutk_arith_cfg_tile.sv
// Randomized bench for frac_lutk_arith_cfg_tile against a table-lookup reference model.
module tb_frac_lutk_arith_cfg_tile;
  localparam int K    = 4;
  localparam int SN   = 1 << K;
  localparam int HALF = SN / 2;
`ifdef FRAC_LUTK_CFG_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int CL = SN + 2 + PW;

  logic         prog_clk = 1'b0;
  logic         pReset = 1'b1;
  logic         config_enable = 1'b0;
  logic         ccff_head = 1'b0;
  logic         cin = 1'b0;
  logic [K-1:0] frac_in = '0;
  logic         ccff_tail, lut_out, cout, cfg_done, cfg_err;
  logic [1:0]   lut_half_out;

  frac_lutk_arith_cfg_tile #(.LUT_K(K), .MODE_W(2)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .config_enable(config_enable),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .frac_in(frac_in), .cin(cin),
    .lut_half_out(lut_half_out), .lut_out(lut_out), .cout(cout),
    .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  int tests = 0;
  int fails = 0;
  int model_sram = 0;
  bit model_arith = 0;

  function automatic logic [CL-1:0] mk_word(input logic [SN-1:0] s, input logic [1:0] m);
`ifdef FRAC_LUTK_CFG_PARITY_EN
    mk_word = {^{m, s}, m, s};
`else
    mk_word = {m, s};
`endif
  endfunction

  function automatic bit par_good(input logic [CL-1:0] w);
`ifdef FRAC_LUTK_CFG_PARITY_EN
    par_good = ((^w) == 1'b0);
`else
    par_good = 1'b1;
`endif
  endfunction

  // Reference: {cout, lut_out, hi, lo} from the model table by plain lookup.
  function automatic logic [3:0] ref_out(input int fi, input bit c);
    int ix, lo, hi, lut, co;
    ix = fi % HALF;
    lo = (model_sram >> ix) & 1;
    hi = (model_sram >> (HALF + ix)) & 1;
    if (model_arith) begin
      lut = lo ^ int'(c);
      co  = (lo == 1) ? int'(c) : hi;
    end else begin
      lut = (fi >= HALF) ? hi : lo;
      co  = 0;
    end
    ref_out = {co[0], lut[0], hi[0], lo[0]};
  endfunction

  // pre random bits, then the top n bits of w, MSB first; then drop enable and let commit finish.
  task automatic load(input logic [CL-1:0] w, input int pre, input int n);
    for (int i = 0; i < pre; i++) begin
      @(negedge prog_clk); config_enable = 1'b1; ccff_head = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < n; i++) begin
      @(negedge prog_clk); config_enable = 1'b1; ccff_head = w[CL-1-i];
    end
    @(negedge prog_clk); config_enable = 1'b0; ccff_head = 1'b0;
    @(posedge prog_clk); @(posedge prog_clk); @(negedge prog_clk);
    if (n == CL && par_good(w)) begin
      model_sram  = int'(w[SN-1:0]);
      model_arith = w[SN+1];
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({ccff_tail, lut_out, cout, cfg_done, cfg_err, lut_half_out} !== 7'b0) begin
      fails++; $display("FAIL reset_in outputs got %b want 0", {ccff_tail, lut_out, cout, cfg_done, cfg_err, lut_half_out});
    end
    @(negedge prog_clk); pReset = 1'b0;
    repeat (3) @(negedge prog_clk);
    tests++;
    if ({ccff_tail, lut_out, cout, cfg_done, cfg_err, lut_half_out} !== 7'b0) begin
      fails++; $display("FAIL reset_release outputs got %b want 0", {ccff_tail, lut_out, cout, cfg_done, cfg_err, lut_half_out});
    end
  endtask

  task automatic test_and4();
    logic [CL-1:0] w;
    logic [3:0] e;
    w = mk_word(16'h8000, 2'b00);
    load(w, 0, CL);
    tests++;
    if ({cfg_done, cfg_err} !== 2'b10) begin
      fails++; $display("FAIL and4_status done/err got %b want 10", {cfg_done, cfg_err});
    end
    tests++;
    if (ccff_tail !== w[CL-1]) begin
      fails++; $display("FAIL and4_tail got %b want %b", ccff_tail, w[CL-1]);
    end
    frac_in = 4'b1111; #1;
    e = ref_out(15, 1'b0);
    tests++;
    if (lut_out !== 1'b1 || lut_out !== e[2]) begin
      fails++; $display("FAIL and4_1111 lut_out got %b want 1", lut_out);
    end
    frac_in = 4'b0111; #1;
    tests++;
    if (lut_out !== 1'b0) begin
      fails++; $display("FAIL and4_0111 lut_out got %b want 0", lut_out);
    end
  endtask

  task automatic test_partial();
    load(mk_word(16'hFFFF, 2'b11), 0, 10);
    tests++;
    if ({cfg_done, cfg_err} !== 2'b01) begin
      fails++; $display("FAIL partial_status done/err got %b want 01", {cfg_done, cfg_err});
    end
    frac_in = 4'b1111; cin = 1'b0; #1;
    tests++;
    if ({cout, lut_out} !== 2'b01) begin
      fails++; $display("FAIL partial_keep {cout,lut_out} got %b want 01", {cout, lut_out});
    end
    frac_in = 4'b1011; #1;
    tests++;
    if ({cout, lut_out} !== 2'b00) begin
      fails++; $display("FAIL partial_keep2 {cout,lut_out} got %b want 00", {cout, lut_out});
    end
  endtask

  task automatic test_arith();
    load(mk_word(16'h8866, 2'b10), 0, CL);
    tests++;
    if ({cfg_done, cfg_err} !== 2'b10) begin
      fails++; $display("FAIL arith_status done/err got %b want 10", {cfg_done, cfg_err});
    end
    frac_in = 4'b0011; cin = 1'b1; #1;
    tests++;
    if ({cout, lut_out} !== 2'b11) begin
      fails++; $display("FAIL arith_11 {cout,lut_out} got %b want 11", {cout, lut_out});
    end
    frac_in = 4'b0001; cin = 1'b1; #1;
    tests++;
    if ({cout, lut_out} !== 2'b10) begin
      fails++; $display("FAIL arith_01 {cout,lut_out} got %b want 10", {cout, lut_out});
    end
  endtask

  task automatic test_mid_reset();
    logic [CL-1:0] w;
    load(mk_word(16'hFFFF, 2'b00), 0, CL);
    for (int i = 0; i < 9; i++) begin
      @(negedge prog_clk); config_enable = 1'b1; ccff_head = 1'b1;
    end
    @(negedge prog_clk); frac_in = 4'b0101;
    pReset = 1'b1; config_enable = 1'b0; #1;
    model_sram = 0; model_arith = 0;
    tests++;
    if ({ccff_tail, lut_out, cout, cfg_done, cfg_err, lut_half_out} !== 7'b0) begin
      fails++; $display("FAIL midreset outputs got %b want 0", {ccff_tail, lut_out, cout, cfg_done, cfg_err, lut_half_out});
    end
    @(negedge prog_clk); pReset = 1'b0;
    w = mk_word(16'hA5C3, 2'b00);
    load(w, 0, CL);
    tests++;
    if ({cfg_done, cfg_err} !== 2'b10) begin
      fails++; $display("FAIL midreset_reload done/err got %b want 10", {cfg_done, cfg_err});
    end
    frac_in = 4'b1110; #1;
    tests++;
    if (lut_half_out !== ref_out(14, 1'b0)) begin
      fails++; $display("FAIL midreset_lookup half got %b want %b", lut_half_out, ref_out(14, 1'b0)[1:0]);
    end
  endtask

  task automatic test_random();
    logic [CL-1:0] w;
    logic [3:0]    e;
    int            pre, n, fi;
    bit            c, ok;
    for (int l = 0; l < 12; l++) begin
      w   = mk_word(16'($urandom), 2'($urandom));
      pre = 0;
      n   = CL;
      if ((l % 4) == 3) n = $urandom_range(1, CL - 1);
      else pre = $urandom_range(0, 3);
      ok = (n == CL) && par_good(w);
      load(w, pre, n);
      tests++;
      if ({cfg_done, cfg_err} !== {ok, !ok}) begin
        fails++; $display("FAIL rand_status load %0d done/err got %b want %b", l, {cfg_done, cfg_err}, {ok, !ok});
      end
      if (n == CL) begin
        tests++;
        if (ccff_tail !== w[CL-1]) begin
          fails++; $display("FAIL rand_tail load %0d got %b want %b", l, ccff_tail, w[CL-1]);
        end
      end
      for (int j = 0; j < 8; j++) begin
        fi = $urandom_range(0, SN - 1);
        c  = 1'($urandom_range(0, 1));
        @(negedge prog_clk); frac_in = K'(fi); cin = c; #1;
        e = ref_out(fi, c);
        tests++;
        if ({cout, lut_out, lut_half_out} !== e) begin
          fails++; $display("FAIL rand_lookup load %0d in %0d cin %b got %b want %b", l, fi, c, {cout, lut_out, lut_half_out}, e);
        end
      end
    end
  endtask

`ifdef FRAC_LUTK_CFG_PARITY_EN
  task automatic test_parity();
    logic [CL-1:0] w;
    int            keep;
    keep = model_sram;
    w = mk_word(16'h0007, 2'b00);
    w[CL-1] = ~w[CL-1];
    load(w, 0, CL);
    tests++;
    if ({cfg_done, cfg_err} !== 2'b01 || model_sram != keep) begin
      fails++; $display("FAIL parity_bad done/err got %b want 01", {cfg_done, cfg_err});
    end
    w[CL-1] = ~w[CL-1];
    load(w, 0, CL);
    frac_in = 4'b0010; #1;
    tests++;
    if ({cfg_done, cfg_err, lut_out} !== 3'b101) begin
      fails++; $display("FAIL parity_good done/err/lut got %b want 101", {cfg_done, cfg_err, lut_out});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_and4();
    test_partial();
    test_arith();
    test_mid_reset();
    test_random();
`ifdef FRAC_LUTK_CFG_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests %0d", tests);
    $fatal(1, "timeout");
  end
endmodule
